if_stage_s: RTL and testbench
=============================

# if_stage_s

Instruction-fetch stage of the 5-stage pipeline, sitting directly upstream of the hazard detection unit and decode. It owns the PC, issues sequential fetch requests to instruction memory over a valid/ready request and valid-only response interface, and buffers returned instructions in a small FIFO. It drives the IF/ID pipeline register, which obeys `stall` (hold) and `flush` (redirect plus bubble).

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC after reset.
- `DEPTH`, 4: capacity of the instruction FIFO, which is also the credit limit. Power of two, ≥2.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: from hazard unit; hold IF/ID.
- `flush` in 1: branch/jump taken in EX; redirect to `target_pc`.
- `target_pc` in 32: redirect address, word aligned.
- `imem_req_valid` out 1: fetch request.
- `imem_req_addr` out 32: fetch address (= `pc`).
- `imem_req_ready` in 1: memory accepts the request.
- `imem_rsp_valid` in 1: response strobe. Responses are in order, one per accepted request, with latency ≥1.
- `imem_rsp_data` in 32: instruction word.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `ifid_pc` out 32: PC of the IF/ID instruction.
- `ifid_pc4` out 32: `ifid_pc` + 4.
- `ifid_instr` out 32: instruction, or NOP 32'h0000_0013 when invalid.

## Operation
State:
- `pc`: next request address.
- `rsp_pc`: address of the next response.
- `out_cnt`: in-flight requests, range 0..DEPTH.
- `drop_cnt`: in-flight responses to discard.
- FIFO: `DEPTH` entries of {pc, instr}, with `count`, read pointer and write pointer.

Request:
- `imem_req_valid` = !rst && !flush && (`out_cnt` + `count` < `DEPTH`). Combinational.
- `imem_req_addr` = `pc`.
- Handshake (valid && ready): `pc` += 4 and `out_cnt` += 1.

Response (`imem_rsp_valid`):
- `out_cnt` −1 on every response.
- If `flush` is high or `drop_cnt` != 0, the response is discarded. `drop_cnt` −1 if nonzero; `rsp_pc` is unchanged.
- Otherwise push {`rsp_pc`, `imem_rsp_data`} into the FIFO and `rsp_pc` += 4.
- The credit rule guarantees no push into a full FIFO. An overflow is a bench assertion failure.

IF/ID register, by priority:
1. `rst`: `ifid_valid` = 0, `ifid_pc` = 0, `ifid_pc4` = 4, `ifid_instr` = 0x13.
2. `flush`: load a bubble (`ifid_valid` = 0, `ifid_instr` = 0x13; pc fields hold). `stall` is ignored.
3. `stall`: hold all IF/ID outputs; no FIFO pop.
4. FIFO nonempty: pop the head into IF/ID with `ifid_valid` = 1.
5. FIFO empty: load a bubble.

Flush, on the same edge:
- `pc` and `rsp_pc` ← `target_pc`.
- FIFO cleared (count 0, pointers 0).
- `drop_cnt` ← `out_cnt` − (`imem_rsp_valid` ? 1 : 0), i.e. all still-outstanding old requests.
- No request is issued in the flush cycle.

Arithmetic: PC adds are 32-bit wrapping; 32'hFFFF_FFFC + 4 = 0.

Reset: `pc` = `rsp_pc` = `RESET_PC`; `out_cnt`, `drop_cnt` and FIFO cleared; IF/ID as priority 1 above. Responses arriving during reset are ignored.

## Timing
- Response in cycle N → pushed at the end of N → popped at the end of N+1 (if no stall) → `ifid_valid` = 1 in cycle N+2.
- After reset deasserts in cycle 0, the first request is issued in cycle 0. With 1-cycle memory, the first `ifid_valid` is in cycle 3.
- Throughput: one instruction per cycle with 1-cycle memory and `DEPTH` ≥ 2 + latency.
- Stall while the FIFO fills: requests continue until `out_cnt` + `count` = `DEPTH`, then `imem_req_valid` drops. It resumes the cycle after the first pop.
- Flush in cycle F: the first request to `target_pc` is issued in F+1. Old in-flight responses never reach IF/ID.
- Simultaneous push and pop: both take effect and `count` is unchanged.
- Simultaneous `stall` and `flush`: flush wins.
- Reset mid-operation: next cycle is the full reset state; in-flight responses after reset are counted by nobody. The bench keeps memory quiet for latency cycles after `rst`.

## Test plan
- **Reset:** `rst` for 2 cycles, 1-cycle memory, `RESET_PC` = 0. Required: `ifid_valid` = 0 and `ifid_instr` = 0x13 during reset; from cycle 3, `ifid_pc` = 0, 4, 8, … one per cycle, with `ifid_instr` matching memory.
- **Stall hold:** assert `stall` for 6 cycles with `ifid_pc` = 0x10. Required: IF/ID holds 0x10; `imem_req_valid` drops once 4 credits are used; after release, `ifid_pc` = 0x14, 0x18, … with no gap and no duplicate.
- **Flush with in-flight requests:** 3-cycle memory, 2 requests outstanding, `flush` with `target_pc` = 0x100. Required: the 2 old responses are discarded; next valid `ifid_pc` = 0x100, then 0x104.
- **Flush with stall:** `flush` and `stall` high in the same cycle. Required: `ifid_valid` = 0 next cycle and the FIFO is empty.
- **Backpressure:** `imem_req_ready` toggles 1,0,0,1. Required: `imem_req_addr` is stable while not ready; the `ifid_pc` sequence stays contiguous.
- **Wrap:** `target_pc` = 0xFFFF_FFF8. Required: `ifid_pc` = 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, and `ifid_pc4` for the last entry = 4.

Source files
------------

// File: rtl/if_stage_s.sv
// rtl/if_stage_s.sv - instruction fetch stage: credit-limited fetch, response FIFO and IF/ID register
module if_stage_s #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] target_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr
);
    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];

    logic [CW:0] credit_used;
    logic        req_fire;
    logic        push;
    logic        pop;

    // Every in-flight request owns a FIFO slot, so a push can never find the FIFO full.
    assign credit_used    = {1'b0, out_cnt} + {1'b0, count};
    assign imem_req_valid = !rst && !flush && (credit_used < DEPTH_W);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push = imem_rsp_valid && !rst && !flush && (drop_cnt == '0);
    assign pop  = !rst && !flush && !stall && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            rsp_pc   <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            // Everything still outstanding belongs to the wrong path and must be discarded.
            pc       <= target_pc;
            rsp_pc   <= target_pc;
            out_cnt  <= out_cnt - CW'(imem_rsp_valid);
            drop_cnt <= out_cnt - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + 32'd4;
            end
            out_cnt <= out_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
            if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= rsp_pc;
            fifo_instr[wr_ptr] <= imem_rsp_data;
        end
    end

    // Bubbles keep the pc fields so downstream still sees a coherent address.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid <= 1'b0;
            ifid_pc    <= 32'd0;
            ifid_pc4   <= 32'd4;
            ifid_instr <= NOP;
        end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP;
        end else if (!stall) begin
            if (pop) begin
                ifid_valid <= 1'b1;
                ifid_pc    <= fifo_pc[rd_ptr];
                ifid_pc4   <= fifo_pc[rd_ptr] + 32'd4;
                ifid_instr <= fifo_instr[rd_ptr];
            end else begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP;
            end
        end
    end
endmodule

// File: tb/tb_if_stage_s.sv
// tb/tb_if_stage_s.sv - self-checking bench for if_stage_s with memory model and IF/ID scoreboard
module tb_if_stage_s;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] target_pc = 32'd0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int mem_lat = 1;
    logic bp_mode = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    logic slot_v [64];
    logic [31:0] slot_a [64];
    logic [31:0] sb [$];
    logic [31:0] exp_req = RESET_PC;

    typedef enum logic [1:0] {K_N, K_S, K_F, K_R} kind_t;
    kind_t prev_kind = K_R;

    if_stage_s #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .target_pc(target_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4), .ifid_instr(ifid_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Mid-cycle sample: scoreboard check of IF/ID, then request bookkeeping and response scheduling.
    task automatic mid();
        logic [31:0] e;
        @(negedge clk);
        slot_v[cyc % 64] = 1'b0;
        if (prev_kind == K_N && ifid_valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: ifid_pc=%h but no instruction expected", ifid_pc);
            end else begin
                e = sb.pop_front();
                if (ifid_pc !== e || ifid_pc4 !== e + 32'd4 || ifid_instr !== mem_word(e)) begin
                    fails++;
                    $display("FAIL sb_ifid: got pc=%h pc4=%h instr=%h, expected pc=%h pc4=%h instr=%h",
                             ifid_pc, ifid_pc4, ifid_instr, e, e + 32'd4, mem_word(e));
                end
            end
        end else if (prev_kind != K_S) begin
            tests++;
            if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
                fails++;
                $display("FAIL sb_bubble: got valid=%b instr=%h, expected valid=0 instr=%h", ifid_valid, ifid_instr, NOP);
            end
        end
        tests++;
        if (dut.push === 1'b1 && int'(dut.count) == DEPTH) begin
            fails++;
            $display("FAIL fifo_overflow: push with count=%0d, expected count<%0d", dut.count, DEPTH);
        end
        if (rst) begin
            for (int i = 0; i < 64; i++) slot_v[i] = 1'b0;
            sb.delete();
            exp_req = RESET_PC;
            prev_kind = K_R;
        end else if (flush) begin
            tests++;
            if (imem_req_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_req: got req_valid=%b, expected 0", imem_req_valid);
            end
            sb.delete();
            exp_req = target_pc;
            prev_kind = K_F;
        end else begin
            if (imem_req_valid === 1'b1 && imem_req_ready) begin
                tests++;
                if (imem_req_addr !== exp_req) begin
                    fails++;
                    $display("FAIL req_addr: got %h, expected %h", imem_req_addr, exp_req);
                end
                sb.push_back(exp_req);
                slot_v[(cyc + mem_lat) % 64] = 1'b1;
                slot_a[(cyc + mem_lat) % 64] = imem_req_addr;
                exp_req = exp_req + 32'd4;
            end
            prev_kind = stall ? K_S : K_N;
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        cyc++;
        #1;
        imem_rsp_valid = slot_v[cyc % 64];
        imem_rsp_data  = slot_v[cyc % 64] ? mem_word(slot_a[cyc % 64]) : 32'hDEAD_BEEF;
        imem_req_ready = bp_mode ? bp_pat[cyc % 4] : 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        mid(); nxt(); mid(); nxt();
        rst = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        int k;
        mem_lat = 1; bp_mode = 1'b0; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mid();
            check("reset_valid", 32'(ifid_valid), 32'd0);
            check("reset_instr", ifid_instr, NOP);
            check("reset_pc", ifid_pc, 32'd0);
            check("reset_pc4", ifid_pc4, 32'd4);
            check("reset_req_valid", 32'(imem_req_valid), 32'd0);
            nxt();
        end
        rst = 1'b0;
        for (k = 0; k < 10; k++) begin
            mid();
            if (k == 0) begin
                check("first_req_valid", 32'(imem_req_valid), 32'd1);
                check("first_req_addr", imem_req_addr, RESET_PC);
            end
            if (ifid_valid === 1'b1) break;
            nxt();
        end
        check("first_valid_cycle", 32'(k), 32'd3);
        check("first_valid_pc", ifid_pc, RESET_PC);
        nxt();
        for (int j = 0; j < 2; j++) begin
            mid();
            check("stream_valid", 32'(ifid_valid), 32'd1);
            nxt();
        end
    endtask

    task automatic test_stall();
        int hs = 0;
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            mid();
            if (ifid_valid === 1'b1 && ifid_pc === 32'h0C) begin
                found = 1'b1;
                break;
            end
            nxt();
        end
        check("stall_find_0c", 32'(found), 32'd1);
        nxt();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mid();
            check("stall_hold_pc", ifid_pc, 32'h10);
            check("stall_hold_valid", 32'(ifid_valid), 32'd1);
            if (imem_req_valid === 1'b1 && imem_req_ready) hs++;
            if (i == 5) check("stall_req_dropped", 32'(imem_req_valid), 32'd0);
            nxt();
        end
        stall = 1'b0;
        check("stall_req_count", 32'(hs), 32'd2);
        for (int j = 0; j < 8; j++) begin
            mid();
            check("release_no_gap", 32'(ifid_valid), 32'd1);
            if (j == 0) check("release_req_still_off", 32'(imem_req_valid), 32'd0);
            if (j == 1) check("release_req_resumed", 32'(imem_req_valid), 32'd1);
            nxt();
        end
    endtask

    task automatic test_flush_inflight();
        int rel;
        mem_lat = 3;
        do_reset();
        mid(); nxt(); mid(); nxt();
        flush = 1'b1; target_pc = 32'h100;
        mid(); nxt();
        flush = 1'b0;
        mid();
        check("redirect_req_valid", 32'(imem_req_valid), 32'd1);
        check("redirect_req_addr", imem_req_addr, 32'h100);
        nxt();
        for (rel = 2; rel < 16; rel++) begin
            mid();
            if (ifid_valid === 1'b1) break;
            nxt();
        end
        check("flush_first_valid_rel", 32'(rel), 32'd6);
        check("flush_first_pc", ifid_pc, 32'h100);
        nxt();
        mid();
        check("flush_second_valid", 32'(ifid_valid), 32'd1);
        check("flush_second_pc", ifid_pc, 32'h104);
        nxt();
    endtask

    task automatic test_flush_stall();
        int rel;
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid(); nxt();
        end
        flush = 1'b1; target_pc = 32'h200;
        mid(); nxt();
        flush = 1'b0; stall = 1'b0;
        for (rel = 1; rel < 16; rel++) begin
            mid();
            if (rel == 1) begin
                check("fs_bubble_valid", 32'(ifid_valid), 32'd0);
                check("fs_bubble_instr", ifid_instr, NOP);
            end
            if (ifid_valid === 1'b1) break;
            nxt();
        end
        check("fs_first_valid_rel", 32'(rel), 32'd6);
        check("fs_first_pc", ifid_pc, 32'h200);
        nxt();
    endtask

    task automatic test_backpressure();
        bit prev_wait = 1'b0;
        logic [31:0] prev_addr = 32'd0;
        int n_valid = 0;
        mem_lat = 1; bp_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            mid();
            if (prev_wait) begin
                check("bp_valid_held", 32'(imem_req_valid), 32'd1);
                check("bp_addr_stable", imem_req_addr, prev_addr);
            end
            prev_wait = (imem_req_valid === 1'b1) && !imem_req_ready;
            prev_addr = imem_req_addr;
            if (ifid_valid === 1'b1) n_valid++;
            nxt();
        end
        bp_mode = 1'b0;
        tests++;
        if (n_valid < 6) begin
            fails++;
            $display("FAIL bp_progress: got %0d instructions, expected at least 6", n_valid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [3];
        int n = 0;
        want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
        flush = 1'b1; target_pc = 32'hFFFF_FFF8;
        mid(); nxt();
        flush = 1'b0;
        for (int i = 0; i < 20; i++) begin
            mid();
            if (ifid_valid === 1'b1) begin
                check("wrap_pc", ifid_pc, want[n]);
                check("wrap_pc4", ifid_pc4, want[n] + 32'd4);
                n++;
                if (n == 3) break;
            end
            nxt();
        end
        check("wrap_count", 32'(n), 32'd3);
        check("wrap_last_pc4", ifid_pc4, 32'd4);
        nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            slot_v[i] = 1'b0;
            slot_a[i] = 32'd0;
        end
        nxt();
        test_reset();
        test_stall();
        test_flush_inflight();
        test_flush_stall();
        test_backpressure();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
